mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide unit with its sequencing controller, for the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from EX and owns the HI/LO registers.
- Holds busy for a fixed cycle count per operation.
- Drives the stall request that freezes IF/ID while a dependent MDU instruction waits in ID.

---
 rtl/mdu_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mdu_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit for the 5-stage MIPS pipeline.
// Owns HI/LO, holds busy for a fixed cycle count per op and raises the ID-stage stall.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_in_id,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [31:0]        hi_r, hi_nxt_s;
  logic [31:0]        lo_r, lo_nxt_s;
  logic [31:0]        pend_hi_r, pend_hi_nxt_s;
  logic [31:0]        pend_lo_r, pend_lo_nxt_s;
  logic               pend_wr_r, pend_wr_nxt_s;
  logic [63:0]        mul_res_s;
  logic [63:0]        div_res_s;
  logic               is_md_op_s;

  // Full 64-bit product; sign- or zero-extension makes one 64-bit multiply serve both forms.
  function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}; signed form divides magnitudes so INT_MIN / -1 wraps cleanly.
  function automatic logic [63:0] div_full(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    mag_a = neg_a ? (~a + 32'd1) : a;
    mag_b = neg_b ? (~b + 32'd1) : b;
    if (mag_b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = mag_a / mag_b;
      r = mag_a % mag_b;
    end
    if (neg_a ^ neg_b) begin
      q = ~q + 32'd1;
    end
    if (neg_a) begin
      r = ~r + 32'd1;
    end
    return {r, q};
  endfunction

  assign mul_res_s  = mul_full(src_a, src_b, op == OP_MULT);
  assign div_res_s  = div_full(src_a, src_b, op == OP_DIV);
  assign is_md_op_s = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

  assign busy  = (state_r == ST_RUN);
  assign stall = md_in_id & (busy | (start & is_md_op_s));
  assign hi    = hi_r;
  assign lo    = lo_r;

  // Next-state, counter, pending-result and HI/LO update logic.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    hi_nxt_s      = hi_r;
    lo_nxt_s      = lo_r;
    pend_hi_nxt_s = pend_hi_r;
    pend_lo_nxt_s = pend_lo_r;
    pend_wr_nxt_s = pend_wr_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pend_hi_nxt_s = mul_res_s[63:32];
              pend_lo_nxt_s = mul_res_s[31:0];
              pend_wr_nxt_s = 1'b1;
              cnt_nxt_s     = CNT_W'(MULT_CYCLES);
              state_nxt_s   = ST_RUN;
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor still runs the full sequence but leaves HI/LO alone.
              pend_hi_nxt_s = div_res_s[63:32];
              pend_lo_nxt_s = div_res_s[31:0];
              pend_wr_nxt_s = (src_b != 32'd0);
              cnt_nxt_s     = CNT_W'(DIV_CYCLES);
              state_nxt_s   = ST_RUN;
            end
            OP_MTHI: hi_nxt_s = src_a;
            OP_MTLO: lo_nxt_s = src_a;
            default: state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s   = ST_IDLE;
          cnt_nxt_s     = {CNT_W{1'b0}};
          pend_wr_nxt_s = 1'b0;
          if (pend_wr_r) begin
            hi_nxt_s = pend_hi_r;
            lo_nxt_s = pend_lo_r;
          end else begin
            hi_nxt_s = hi_r;
            lo_nxt_s = lo_r;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        cnt_nxt_s     = {CNT_W{1'b0}};
        pend_wr_nxt_s = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      hi_r      <= hi_nxt_s;
      lo_r      <= lo_nxt_s;
      pend_hi_r <= pend_hi_nxt_s;
      pend_lo_r <= pend_lo_nxt_s;
      pend_wr_r <= pend_wr_nxt_s;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed-vector bench for mdu_ctrl with hand-computed HI/LO, busy-length and stall expectations.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_in_id;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int vec_cnt = 0;
  int err_cnt = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .md_in_id(md_in_id), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [3:0] o, input logic [31:0] a);
    op = o; src_a = a; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
  endtask

  // Issue an op, count busy cycles (bounded), optionally check stall and inject a mid-run start.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n_exp, input logic md, input int inj,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    op = o; src_a = a; src_b = b; start = 1'b1; md_in_id = md;
    #1;
    if (md) chk_val({tag, "_stall_issue"}, {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0; op = 4'd0;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      start = (n == inj);
      op    = (n == inj) ? 4'd3 : 4'd0;
      src_a = 32'd1000; src_b = 32'd3;
      #1;
      if (md) chk_val({tag, "_stall_busy"}, {31'd0, stall}, 32'd1);
      tick();
    end
    start = 1'b0; op = 4'd0;
    #1;
    chk_val({tag, "_cycles"}, n, n_exp);
    chk_val({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    if (md) chk_val({tag, "_stall_end"}, {31'd0, stall}, 32'd0);
    chk_val({tag, "_hi"}, hi, exp_hi);
    chk_val({tag, "_lo"}, lo, exp_lo);
    md_in_id = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 4'd0; src_a = 32'd0; src_b = 32'd0; md_in_id = 1'b0;
    tick(); tick();
    reset = 1'b1;

    // Traffic, then a one-edge reset
    single(4'd5, 32'hDEADBEEF);
    single(4'd6, 32'h0BADF00D);
    op = 4'd1; src_a = 32'h12345678; src_b = 32'h9ABCDEF0; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    tick();
    reset = 1'b0; md_in_id = 1'b1;
    tick();
    reset = 1'b1;
    chk_val("rst_hi", hi, 32'h0);
    chk_val("rst_lo", lo, 32'h0);
    chk_val("rst_busy", {31'd0, busy}, 32'd0);
    chk_val("rst_stall", {31'd0, stall}, 32'd0);
    md_in_id = 1'b0;
    repeat (8) tick();
    chk_val("rst_nocommit_hi", hi, 32'h0);

    // Multiply / divide results and busy lengths; consecutive ops have no dead cycles
    run_op("mult",  4'd1, 32'hFFFFFFFE, 32'd3, 5, 1'b0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5, 1'b0, 0, 32'h00000002, 32'hFFFFFFFA);
    run_op("div",   4'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",  4'd4, 32'd7, 32'd2, 10, 1'b0, 0, 32'd1, 32'd3);
    run_op("div_nb", 4'd3, 32'd7, 32'hFFFFFFFE, 10, 1'b0, 0, 32'd1, 32'hFFFFFFFD);
    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 0, 32'h0, 32'h80000000);
    run_op("divu_big", 4'd4, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 0, 32'h80000000, 32'h0);

    // MTHI/MTLO then divide by zero
    single(4'd5, 32'h1234);
    chk_val("mthi_busy", {31'd0, busy}, 32'd0);
    chk_val("mthi_hi", hi, 32'h1234);
    single(4'd6, 32'h5678);
    chk_val("mtlo_lo", lo, 32'h5678);
    chk_val("mtlo_hi", hi, 32'h1234);
    run_op("div0", 4'd3, 32'd5, 32'd0, 10, 1'b0, 0, 32'h1234, 32'h5678);

    // Undefined opcode does nothing
    src_b = 32'd1;
    single(4'd9, 32'hFFFF0000);
    chk_val("nop_busy", {31'd0, busy}, 32'd0);
    chk_val("nop_hi", hi, 32'h1234);
    chk_val("nop_lo", lo, 32'h5678);

    // Stall through a MULT, with an ignored DIV strobe mid-run
    run_op("mult_stall", 4'd1, 32'd100, 32'hFFFFFFFF, 5, 1'b1, 2, 32'hFFFFFFFF, 32'hFFFFFF9C);

    // Reset in busy cycle 3 of DIV 100/7 drops the result
    single(4'd5, 32'hAAAA);
    single(4'd6, 32'hAAAA);
    op = 4'd3; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    chk_val("rstmid_busy1", {31'd0, busy}, 32'd1);
    tick(); tick();
    chk_val("rstmid_busy3", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_val("rstmid_busy", {31'd0, busy}, 32'd0);
    chk_val("rstmid_hi", hi, 32'h0);
    chk_val("rstmid_lo", lo, 32'h0);
    repeat (15) tick();
    chk_val("rstmid_late_busy", {31'd0, busy}, 32'd0);
    chk_val("rstmid_late_hi", hi, 32'h0);
    chk_val("rstmid_late_lo", lo, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
